// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one digit per clock, LSD first, over a single digit adder (BCD_INVALID_CHECK_EN enables err).
// Latency: start edge k -> done pulse in the cycle after edge k+DIGITS; one op per DIGITS+1 cycles.
// Backpressure: none; start is sampled only in IDLE/DONE and ignored while busy, with no queueing.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS) + 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    work_q, work_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
`ifdef BCD_INVALID_CHECK_EN
    logic            inv_q, inv_d;
    logic            err_q, err_d;
`endif

    logic [3:0]      dig_sum;
    logic            dig_co;
    logic [W-1:0]    work_sh;

    // Single-digit BCD add: any raw result above 9 (incl. binary carry) gets +6 and a decimal carry.
    function automatic logic [4:0] bcd_digit(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [4:0] raw;
        raw = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
        if (raw > 5'd9) return {1'b1, raw[3:0] + 4'd6};
        return raw;
    endfunction

`ifdef BCD_INVALID_CHECK_EN
    function automatic logic has_invalid(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction
`endif

    assign {dig_co, dig_sum} = bcd_digit(a_sh_q[3:0], b_sh_q[3:0], carry_q);
    // New digit enters at the MSD end so digit 0 lands at the bottom after DIGITS shifts.
    assign work_sh = W'({dig_sum, work_q} >> 4);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef BCD_INVALID_CHECK_EN
        inv_d   = inv_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = ADD;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    work_d  = '0;
`ifdef BCD_INVALID_CHECK_EN
                    inv_d   = has_invalid(a) | has_invalid(b);
`endif
                end
            end
            ADD: begin
                carry_d = dig_co;
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                work_d  = work_sh;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(DIGITS - 1)) begin
                    state_d = DONE;
`ifdef BCD_INVALID_CHECK_EN
                    if (inv_q) begin
                        sum_d  = '0;
                        cout_d = 1'b0;
                        err_d  = 1'b1;
                    end else begin
                        sum_d  = work_sh;
                        cout_d = dig_co;
                        err_d  = 1'b0;
                    end
`else
                    sum_d  = work_sh;
                    cout_d = dig_co;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef BCD_INVALID_CHECK_EN
            inv_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef BCD_INVALID_CHECK_EN
            inv_q   <= inv_d;
            err_q   <= err_d;
`endif
        end
    end

    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef BCD_INVALID_CHECK_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboarded bench for bcd_serial_add_ctrl: directed cases plus random packed-BCD operands
// checked against decimal integer arithmetic; honours BCD_INVALID_CHECK_EN.
module tb_bcd_serial_add_ctrl;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    int           cyc = 0;
    int           n_total = 0;
    int           n_pass = 0;
    logic [W-1:0] last_sum = '0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           cyc;
    } exp_t;
    exp_t exp_q[$];

    bcd_serial_add_ctrl #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference: {cout, sum} from plain decimal addition of the operand values.
    function automatic logic [W:0] dec_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint lim = 1;
        longint s;
        for (int i = 0; i < D; i++) lim = lim * 10;
        s = bcd2int(x) + bcd2int(y) + longint'(c);
        return {(s >= lim), int2bcd(s % lim)};
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Called at posedge+1 with the DUT in IDLE or DONE; ign_at >= 0 pulses a stray start mid-op.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                          input logic [W-1:0] esum, input logic ecout, input logic eerr,
                          input int gap, input int ign_at);
        exp_t e;
        a = ta; b = tbv; cin = tc; start = 1'b1;
        e.sum = esum; e.cout = ecout; e.err = eerr; e.cyc = cyc + 1 + D;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        for (int i = 0; i < D; i++) begin
            check("busy_during_add", busy, 1);
            check("sum_hold_during_add", sum, last_sum);
            if (i == ign_at) begin
                start = 1'b1;
                a = {D{4'h1}};
                b = {D{4'h1}};
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("busy_low_in_done", busy, 0);
        last_sum = esum;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_done: got done=1 at cycle %0d, expected no pending result", cyc);
            end else begin
                e = exp_q.pop_front();
                check("sum", sum, e.sum);
                check("cout", cout, e.cout);
                check("err", err, e.err);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin : stim
        logic [W:0]   r;
        logic [W-1:0] ra, rb;
        logic         rc;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1, -1);
        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1, 1);
        run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1, -1);
        run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 0, -1);
        run_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1, -1);

`ifdef BCD_INVALID_CHECK_EN
        run_op(16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1, -1);
`else
        run_op(16'h12A4, 16'h0001, 1'b0, 16'h1305, 1'b0, 1'b0, 1, -1);
`endif
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1, -1);

        // Leave a nonzero sum/cout behind so the abort clearing is observable.
        run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1, -1);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_sum = '0;
        run_op(16'h4321, 16'h1234, 1'b1, 16'h5556, 1'b0, 1'b0, 1, -1);

        for (int n = 0; n < 30; n++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            rc = 1'($urandom);
            r  = dec_add(ra, rb, rc);
            run_op(ra, rb, rc, r[W-1:0], r[W], 1'b0, $urandom_range(0, 2), -1);
        end

        repeat (D + 3) @(posedge clk);
        #1;
        check("all_results_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
